// File: rtl/sram_pb_error_handler_pkg.sv
// Shared helpers for the parity-error handler slice.
// Log pointers carry one extra MSB so a full log is distinguishable from an empty one.
package sram_pb_error_handler_pkg;

   function automatic int unsigned log_ptr_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sram_pb_error_handler_sat_counter.sv
// Saturating up-counter with clear; clear together with increment loads one.
module sram_pb_error_handler_sat_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = inc_i ? WIDTH'(1) : '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/sram_pb_error_handler.sv
// Logs parity-failing read addresses, scrubs them through the shared SRAM write port
// and exposes a repaired-error log, saturating count and level interrupt to software.
module sram_pb_error_handler
   import sram_pb_error_handler_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 10,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           LOG_DEPTH   = 4,
   parameter int unsigned           COUNT_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] SCRUB_DATA  = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sram_read_en,
   input  logic [ADDR_WIDTH-1:0]  sram_read_addr,
   input  logic                   ecc_pb_error,
   input  logic                   fn_write_en,
   input  logic [ADDR_WIDTH-1:0]  fn_write_addr,
   input  logic [DATA_WIDTH-1:0]  fn_write_data,
   output logic                   sram_write_en,
   output logic [ADDR_WIDTH-1:0]  sram_write_addr,
   output logic [DATA_WIDTH-1:0]  sram_write_data,
   output logic                   repair_busy,
   output logic                   err_valid,
   output logic [ADDR_WIDTH-1:0]  err_addr,
   input  logic                   err_pop,
   output logic [COUNT_WIDTH-1:0] err_count,
   output logic                   err_overflow,
   input  logic                   err_clear,
   output logic                   error_irq
);

   localparam int unsigned PW = log_ptr_width(LOG_DEPTH);
   localparam int unsigned IW = PW - 1;

   logic [ADDR_WIDTH-1:0] log_q [LOG_DEPTH];
   logic [PW-1:0]         wr_ptr_q;
   logic [PW-1:0]         wr_ptr_d;
   logic [PW-1:0]         rep_ptr_q;
   logic [PW-1:0]         rep_ptr_d;
   logic [PW-1:0]         rd_ptr_q;
   logic [PW-1:0]         rd_ptr_d;
   logic                  ovf_q;
   logic                  ovf_d;

   logic                  err_det;
   logic                  log_full;
   logic                  pop_acc;
   logic                  push;
   logic                  drop;
   logic                  cand_vld;
   logic [ADDR_WIDTH-1:0] cand_addr;
   logic                  scrub_en;
   logic                  rep_adv;

   // The flag is already gated by read_en upstream; re-gating is harmless and explicit.
   assign err_det  = ecc_pb_error & sram_read_en;
   assign log_full = ((wr_ptr_q - rd_ptr_q) == PW'(LOG_DEPTH));
   assign pop_acc  = err_pop & err_valid;
   assign push     = err_det & (~log_full | pop_acc);
   assign drop     = err_det & log_full & ~pop_acc;

   assign cand_vld  = (rep_ptr_q != wr_ptr_q);
   assign cand_addr = log_q[rep_ptr_q[IW-1:0]];
   assign scrub_en  = cand_vld & ~fn_write_en;
   // A functional write to the candidate re-encodes parity, so it retires the repair too.
   assign rep_adv   = cand_vld & (~fn_write_en | (fn_write_addr == cand_addr));

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rep_ptr_d = rep_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      ovf_d     = ovf_q | drop;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rep_adv) begin
         rep_ptr_d = rep_ptr_q + PW'(1);
      end
      if (pop_acc) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (err_clear) begin
         ovf_d = drop;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rep_ptr_q <= '0;
         rd_ptr_q  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rep_ptr_q <= rep_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ovf_q     <= ovf_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < LOG_DEPTH; i++) begin
            log_q[i] <= '0;
         end
      end else if (push) begin
         log_q[wr_ptr_q[IW-1:0]] <= sram_read_addr;
      end
   end

   sram_pb_error_handler_sat_counter #(
      .WIDTH (COUNT_WIDTH)
   ) u_err_count (
      .clk     (clk),
      .rst_n   (reset),
      .inc_i   (err_det),
      .clr_i   (err_clear),
      .count_o (err_count)
   );

   assign sram_write_en   = fn_write_en | scrub_en;
   assign sram_write_addr = fn_write_en ? fn_write_addr : (scrub_en ? cand_addr : '0);
   assign sram_write_data = fn_write_en ? fn_write_data : (scrub_en ? SCRUB_DATA : '0);

   assign repair_busy  = cand_vld;
   assign err_valid    = (rd_ptr_q != rep_ptr_q);
   assign err_addr     = log_q[rd_ptr_q[IW-1:0]];
   assign error_irq    = (rd_ptr_q != wr_ptr_q);
   assign err_overflow = ovf_q;

endmodule

// File: tb/tb_sram_pb_error_handler.sv
// Scoreboard bench: logged and pending-scrub addresses are queued as stimulus is driven
// and retired as the DUT scrubs them or presents them at the log head.
module tb_sram_pb_error_handler;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;
   localparam int unsigned LD = 4;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          sram_read_en = 1'b0;
   logic [AW-1:0] sram_read_addr = '0;
   logic          ecc_pb_error = 1'b0;
   logic          fn_write_en = 1'b0;
   logic [AW-1:0] fn_write_addr = '0;
   logic [DW-1:0] fn_write_data = '0;
   logic          sram_write_en;
   logic [AW-1:0] sram_write_addr;
   logic [DW-1:0] sram_write_data;
   logic          repair_busy;
   logic          err_valid;
   logic [AW-1:0] err_addr;
   logic          err_pop = 1'b0;
   logic [CW-1:0] err_count;
   logic          err_overflow;
   logic          err_clear = 1'b0;
   logic          error_irq;

   int unsigned   n_checks = 0;
   int unsigned   n_errors = 0;
   logic [AW-1:0] exp_log [$];
   logic [AW-1:0] exp_scrub [$];
   int unsigned   exp_count = 0;
   logic          exp_ovf = 1'b0;

   always #5 clk = ~clk;

   sram_pb_error_handler #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .LOG_DEPTH   (LD),
      .COUNT_WIDTH (CW),
      .SCRUB_DATA  ('0)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .sram_read_en    (sram_read_en),
      .sram_read_addr  (sram_read_addr),
      .ecc_pb_error    (ecc_pb_error),
      .fn_write_en     (fn_write_en),
      .fn_write_addr   (fn_write_addr),
      .fn_write_data   (fn_write_data),
      .sram_write_en   (sram_write_en),
      .sram_write_addr (sram_write_addr),
      .sram_write_data (sram_write_data),
      .repair_busy     (repair_busy),
      .err_valid       (err_valid),
      .err_addr        (err_addr),
      .err_pop         (err_pop),
      .err_count       (err_count),
      .err_overflow    (err_overflow),
      .err_clear       (err_clear),
      .error_irq       (error_irq)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_we"},    sram_write_en,   '0);
      check({tag, "_waddr"}, sram_write_addr, '0);
      check({tag, "_wdata"}, sram_write_data, '0);
      check({tag, "_busy"},  repair_busy,     '0);
      check({tag, "_valid"}, err_valid,       '0);
      check({tag, "_addr"},  err_addr,        '0);
      check({tag, "_count"}, err_count,       '0);
      check({tag, "_ovf"},   err_overflow,    '0);
      check({tag, "_irq"},   error_irq,       '0);
   endtask

   // One clock cycle: compare registered state, drive inputs, compare the write port, update the model.
   task automatic cyc(input logic err, input logic [AW-1:0] ra, input logic fw,
                      input logic [AW-1:0] fa, input logic [DW-1:0] fd,
                      input logic pop, input logic clr);
      logic          valid_pre;
      logic          have_cand;
      logic [AW-1:0] cand;
      logic          evt;
      @(posedge clk);
      #1;
      valid_pre = (exp_log.size() > exp_scrub.size());
      have_cand = (exp_scrub.size() != 0);
      cand      = have_cand ? exp_scrub[0] : '0;
      check("err_count",    err_count,    exp_count);
      check("err_overflow", err_overflow, exp_ovf);
      check("error_irq",    error_irq,    exp_log.size() != 0);
      check("repair_busy",  repair_busy,  have_cand);
      check("err_valid",    err_valid,    valid_pre);
      if (valid_pre) check("err_addr", err_addr, exp_log[0]);

      ecc_pb_error   = err;
      sram_read_en   = err;
      sram_read_addr = ra;
      fn_write_en    = fw;
      fn_write_addr  = fa;
      fn_write_data  = fd;
      err_pop        = pop;
      err_clear      = clr;
      #1;
      check("sram_write_en", sram_write_en, fw | (have_cand & ~fw));
      if (fw) begin
         check("fn_pass_addr", sram_write_addr, fa);
         check("fn_pass_data", sram_write_data, fd);
      end else if (have_cand) begin
         check("scrub_addr", sram_write_addr, cand);
         check("scrub_data", sram_write_data, '0);
      end

      if (pop && valid_pre) void'(exp_log.pop_front());
      if (have_cand && (!fw || fa == cand)) void'(exp_scrub.pop_front());
      evt = 1'b0;
      if (err) begin
         if (exp_log.size() < LD) begin
            exp_log.push_back(ra);
            exp_scrub.push_back(ra);
         end else begin
            evt = 1'b1;
         end
      end
      if (clr) begin
         exp_count = err ? 1 : 0;
         exp_ovf   = evt;
      end else begin
         if (err && exp_count < 255) exp_count++;
         exp_ovf = exp_ovf | evt;
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic error_at(input logic [AW-1:0] a);
      cyc(1'b1, a, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic pop_head();
      cyc(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
   endtask

   task automatic async_reset(input string tag);
      @(posedge clk);
      #3;
      ecc_pb_error  = 1'b0;
      sram_read_en  = 1'b0;
      fn_write_en   = 1'b0;
      fn_write_addr = '0;
      fn_write_data = '0;
      err_pop       = 1'b0;
      err_clear     = 1'b0;
      reset         = 1'b0;
      #1;
      check_zero(tag);
      exp_log.delete();
      exp_scrub.delete();
      exp_count = 0;
      exp_ovf   = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
   endtask

   initial begin
      #2;
      check_zero("por");
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      idle(3);

      // Single error, scrub, pop, then an ignored pop on an empty log
      error_at(10'h080);
      idle(2);
      pop_head();
      pop_head();
      idle(1);

      // Repair blocked by writes elsewhere, then retired by a write to the same word
      error_at(10'h010);
      for (int unsigned i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 10'h020, 32'hA5A5_0000 + i, 1'b0, 1'b0);
      idle(1);
      error_at(10'h011);
      cyc(1'b0, '0, 1'b1, 10'h011, 32'h1234_5678, 1'b0, 1'b0);
      idle(1);
      pop_head();
      pop_head();
      idle(1);

      // Overflow: five errors into a four-entry log
      for (int unsigned i = 1; i <= 5; i++) error_at(AW'(i));
      idle(6);
      for (int unsigned i = 0; i < 4; i++) pop_head();
      idle(1);

      // Full log with a simultaneous pop accepts the push
      cyc(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
      for (int unsigned i = 0; i < 4; i++) error_at(10'h100 + AW'(i));
      idle(5);
      cyc(1'b1, 10'h104, 1'b0, '0, '0, 1'b1, 1'b0);
      idle(2);
      for (int unsigned i = 0; i < 4; i++) pop_head();
      idle(1);

      // Counter saturation, then clear with a simultaneous error
      for (int unsigned i = 0; i < 300; i++) error_at(AW'(10'h200 + i));
      idle(2);
      cyc(1'b1, 10'h3F0, 1'b0, '0, '0, 1'b0, 1'b1);
      idle(2);
      for (int unsigned i = 0; i < 4; i++) pop_head();
      idle(1);

      // Reset while a repair is pending: nothing is scrubbed afterwards
      error_at(10'h0AA);
      cyc(1'b0, '0, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 10'h3FF, 32'hDEAD_BEEF, 1'b0, 1'b0);
      async_reset("mid_reset");
      idle(5);
      error_at(10'h055);
      idle(2);
      pop_head();
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
